// File: rtl/snd_pkg.sv
// Shared constants and helpers for the sound-command mailbox.
package snd_pkg;

    localparam int IRQ_LATCHED = 0;
    localparam int IRQ_LEVEL   = 1;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int snd_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/snd_fifo.sv
// Show-ahead command FIFO with optional replace-newest on a full push.
module snd_fifo
    import snd_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              push,
    input  logic                              pop,
    input  logic                              overwrite_en,
    input  logic [DW-1:0]                     din,
    output logic [DW-1:0]                     head,
    output logic [snd_cnt_width(DEPTH)-1:0]   count,
    output logic                              full,
    output logic                              empty,
    output logic                              empty_nxt,
    output logic                              push_taken,
    output logic                              push_dropped
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = snd_cnt_width(DEPTH);

    logic [DW-1:0] mem_r [DEPTH];
    logic [DW-1:0] mem_s [DEPTH];
    logic [PW-1:0] wr_ptr_r, wr_ptr_s, rd_ptr_r, rd_ptr_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [DW-1:0] head_r;
    logic          full_r, empty_r, pop_s, ins_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        if (p == {PW{1'b0}}) begin
            return PW'(DEPTH - 1);
        end else begin
            return p - PW'(1);
        end
    endfunction

    // Next-state storage, pointers and count for push/pop/overwrite.
    always_comb begin
        mem_s        = mem_r;
        wr_ptr_s     = wr_ptr_r;
        rd_ptr_s     = rd_ptr_r;
        cnt_s        = cnt_r;
        push_taken   = 1'b0;
        push_dropped = 1'b0;
        ins_s        = 1'b0;
        pop_s        = pop && !empty_r;
        if (push) begin
            // A pop in the same cycle frees a slot, so a full FIFO still accepts.
            if (!full_r || pop_s) begin
                mem_s[wr_ptr_r] = din;
                wr_ptr_s        = ptr_inc(wr_ptr_r);
                ins_s           = 1'b1;
                push_taken      = 1'b1;
            end else if (overwrite_en) begin
                mem_s[ptr_dec(wr_ptr_r)] = din;
                push_taken               = 1'b1;
            end else begin
                push_dropped = 1'b1;
            end
        end else begin
            push_taken = 1'b0;
        end
        if (pop_s) begin
            rd_ptr_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
        case ({ins_s, pop_s})
            2'b10:   cnt_s = cnt_r + CW'(1);
            2'b01:   cnt_s = cnt_r - CW'(1);
            default: cnt_s = cnt_r;
        endcase
    end

    assign empty_nxt = (cnt_s == {CW{1'b0}});

    // State registers; head/full/empty are registered from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            head_r   <= {DW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            mem_r    <= mem_s;
            wr_ptr_r <= wr_ptr_s;
            rd_ptr_r <= rd_ptr_s;
            cnt_r    <= cnt_s;
            head_r   <= empty_nxt ? {DW{1'b0}} : mem_s[rd_ptr_s];
            full_r   <= (cnt_s == CW'(DEPTH));
            empty_r  <= empty_nxt;
        end
    end

    assign head  = head_r;
    assign count = cnt_r;
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/snd_cmd_mailbox.sv
// 68000-to-Z80 command mailbox: queued commands, sound IRQ, overflow flag, reply latch.
module snd_cmd_mailbox
    import snd_pkg::*;
#(
    parameter int DW        = 8,
    parameter int DEPTH     = 4,
    parameter int IRQ_MODE  = 0,
    parameter int OVERWRITE = 0
) (
    input  logic                            CLK,
    input  logic                            nRESET,
    input  logic                            M_WR,
    input  logic [DW-1:0]                   M_DIN,
    output logic                            M_FULL,
    output logic                            M_OVF,
    input  logic                            M_OVF_CLR,
    input  logic                            M_RD_REPLY,
    output logic [DW-1:0]                   M_DOUT,
    output logic                            M_REPLY_VALID,
    input  logic                            S_RD,
    output logic [DW-1:0]                   S_DOUT,
    output logic                            S_EMPTY,
    output logic [snd_cnt_width(DEPTH)-1:0] S_COUNT,
    input  logic                            S_IACK,
    output logic                            S_IRQ,
    input  logic                            S_WR_REPLY,
    input  logic [DW-1:0]                   S_DIN
);

    logic          empty_nxt_s, push_taken_s, push_dropped_s;
    logic          irq_r, irq_s, ovf_r, reply_valid_r;
    logic [DW-1:0] reply_r;

    snd_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (CLK),
        .rst_n        (nRESET),
        .push         (M_WR),
        .pop          (S_RD),
        .overwrite_en (OVERWRITE != 0),
        .din          (M_DIN),
        .head         (S_DOUT),
        .count        (S_COUNT),
        .full         (M_FULL),
        .empty        (S_EMPTY),
        .empty_nxt    (empty_nxt_s),
        .push_taken   (push_taken_s),
        .push_dropped (push_dropped_s)
    );

    // Next IRQ: level follows occupancy; latched is set by a stored push, which beats IACK.
    always_comb begin
        irq_s = irq_r;
        if (IRQ_MODE == IRQ_LEVEL) begin
            irq_s = !empty_nxt_s;
        end else if (push_taken_s) begin
            irq_s = 1'b1;
        end else if (S_IACK) begin
            irq_s = 1'b0;
        end else begin
            irq_s = irq_r;
        end
    end

    // IRQ, sticky overflow and reply latch registers.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            irq_r         <= 1'b0;
            ovf_r         <= 1'b0;
            reply_r       <= {DW{1'b0}};
            reply_valid_r <= 1'b0;
        end else begin
            irq_r <= irq_s;
            if (push_dropped_s) begin
                ovf_r <= 1'b1;
            end else if (M_OVF_CLR) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
            if (S_WR_REPLY) begin
                reply_r       <= S_DIN;
                reply_valid_r <= 1'b1;
            end else if (M_RD_REPLY) begin
                reply_valid_r <= 1'b0;
            end else begin
                reply_valid_r <= reply_valid_r;
            end
        end
    end

    assign S_IRQ         = irq_r;
    assign M_OVF         = ovf_r;
    assign M_DOUT        = reply_r;
    assign M_REPLY_VALID = reply_valid_r;

endmodule

// File: tb/tb_snd_cmd_mailbox.sv
// Directed bench: three mailbox flavours (dropping/latched, overwriting/level, legacy 1-deep) on shared strobes.
module tb_snd_cmd_mailbox;

    logic       CLK, nRESET;
    logic       M_WR, M_OVF_CLR, M_RD_REPLY, S_RD, S_IACK, S_WR_REPLY;
    logic [7:0] M_DIN, S_DIN;

    logic       a_full, a_ovf, a_valid, a_empty, a_irq;
    logic [7:0] a_mdout, a_sdout;
    logic [2:0] a_cnt;
    logic       b_full, b_ovf, b_valid, b_empty, b_irq;
    logic [7:0] b_mdout, b_sdout;
    logic [2:0] b_cnt;
    logic       c_full, c_ovf, c_valid, c_empty, c_irq;
    logic [7:0] c_mdout, c_sdout;
    logic [0:0] c_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] a_pop_exp [4] = '{8'h33, 8'h44, 8'h66, 8'h00};
    logic [7:0] b_pop_exp [4] = '{8'h33, 8'h57, 8'h66, 8'h00};

    snd_cmd_mailbox #(.DW(8), .DEPTH(4), .IRQ_MODE(0), .OVERWRITE(0)) u_a (
        .CLK(CLK), .nRESET(nRESET), .M_WR(M_WR), .M_DIN(M_DIN), .M_FULL(a_full),
        .M_OVF(a_ovf), .M_OVF_CLR(M_OVF_CLR), .M_RD_REPLY(M_RD_REPLY), .M_DOUT(a_mdout),
        .M_REPLY_VALID(a_valid), .S_RD(S_RD), .S_DOUT(a_sdout), .S_EMPTY(a_empty),
        .S_COUNT(a_cnt), .S_IACK(S_IACK), .S_IRQ(a_irq), .S_WR_REPLY(S_WR_REPLY), .S_DIN(S_DIN));

    snd_cmd_mailbox #(.DW(8), .DEPTH(4), .IRQ_MODE(1), .OVERWRITE(1)) u_b (
        .CLK(CLK), .nRESET(nRESET), .M_WR(M_WR), .M_DIN(M_DIN), .M_FULL(b_full),
        .M_OVF(b_ovf), .M_OVF_CLR(M_OVF_CLR), .M_RD_REPLY(M_RD_REPLY), .M_DOUT(b_mdout),
        .M_REPLY_VALID(b_valid), .S_RD(S_RD), .S_DOUT(b_sdout), .S_EMPTY(b_empty),
        .S_COUNT(b_cnt), .S_IACK(S_IACK), .S_IRQ(b_irq), .S_WR_REPLY(S_WR_REPLY), .S_DIN(S_DIN));

    snd_cmd_mailbox #(.DW(8), .DEPTH(1), .IRQ_MODE(0), .OVERWRITE(1)) u_c (
        .CLK(CLK), .nRESET(nRESET), .M_WR(M_WR), .M_DIN(M_DIN), .M_FULL(c_full),
        .M_OVF(c_ovf), .M_OVF_CLR(M_OVF_CLR), .M_RD_REPLY(M_RD_REPLY), .M_DOUT(c_mdout),
        .M_REPLY_VALID(c_valid), .S_RD(S_RD), .S_DOUT(c_sdout), .S_EMPTY(c_empty),
        .S_COUNT(c_cnt), .S_IACK(S_IACK), .S_IRQ(c_irq), .S_WR_REPLY(S_WR_REPLY), .S_DIN(S_DIN));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task step();
        @(posedge CLK);
        #1;
        M_WR       = 1'b0;
        S_RD       = 1'b0;
        S_IACK     = 1'b0;
        M_OVF_CLR  = 1'b0;
        M_RD_REPLY = 1'b0;
        S_WR_REPLY = 1'b0;
    endtask

    initial begin
        nRESET = 1'b0; M_WR = 1'b0; M_OVF_CLR = 1'b0; M_RD_REPLY = 1'b0;
        S_RD = 1'b0; S_IACK = 1'b0; S_WR_REPLY = 1'b0; M_DIN = 8'h00; S_DIN = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_a_empty", a_empty, 1);  chk("rst_a_full", a_full, 0);
        chk("rst_a_cnt", a_cnt, 0);      chk("rst_a_irq", a_irq, 0);
        chk("rst_a_ovf", a_ovf, 0);      chk("rst_a_sdout", a_sdout, 0);
        chk("rst_a_mdout", a_mdout, 0);  chk("rst_a_valid", a_valid, 0);
        chk("rst_b_irq", b_irq, 0);      chk("rst_c_empty", c_empty, 1);
        nRESET = 1'b1;

        M_WR = 1'b1; M_DIN = 8'h11; step();
        chk("p11_a_cnt", a_cnt, 1);      chk("p11_a_sdout", a_sdout, 8'h11);
        chk("p11_a_irq", a_irq, 1);      chk("p11_a_empty", a_empty, 0);
        chk("p11_b_irq", b_irq, 1);      chk("p11_c_sdout", c_sdout, 8'h11);
        chk("p11_c_full", c_full, 1);    chk("p11_c_irq", c_irq, 1);

        M_WR = 1'b1; M_DIN = 8'h22; step();
        chk("p22_c_ovw", c_sdout, 8'h22); chk("p22_c_ovf", c_ovf, 0);
        chk("p22_c_cnt", c_cnt, 1);       chk("p22_a_cnt", a_cnt, 2);

        M_WR = 1'b1; M_DIN = 8'h33; step();
        chk("p33_a_cnt", a_cnt, 3);      chk("p33_a_sdout", a_sdout, 8'h11);
        chk("p33_c_sdout", c_sdout, 8'h33);

        S_IACK = 1'b1; step();
        chk("iack_a_irq", a_irq, 0);     chk("iack_b_irq", b_irq, 1);
        chk("iack_c_irq", c_irq, 0);

        M_WR = 1'b1; M_DIN = 8'h44; S_IACK = 1'b1; step();
        chk("p44iack_a_irq", a_irq, 1);  chk("p44_a_full", a_full, 1);
        chk("p44_a_cnt", a_cnt, 4);      chk("p44iack_c_irq", c_irq, 1);
        chk("p44_c_sdout", c_sdout, 8'h44);

        // full: a drops (IACK clears, dropped push must not re-set), b and c overwrite
        M_WR = 1'b1; M_DIN = 8'h55; S_IACK = 1'b1; step();
        chk("p55_a_ovf", a_ovf, 1);      chk("p55_a_irq", a_irq, 0);
        chk("p55_a_cnt", a_cnt, 4);      chk("p55_a_sdout", a_sdout, 8'h11);
        chk("p55_b_ovf", b_ovf, 0);      chk("p55_b_cnt", b_cnt, 4);
        chk("p55_b_irq", b_irq, 1);      chk("p55_c_sdout", c_sdout, 8'h55);
        chk("p55_c_irq", c_irq, 1);

        M_WR = 1'b1; M_DIN = 8'h57; M_OVF_CLR = 1'b1; step();
        chk("ovfclr_push_a_ovf", a_ovf, 1);

        M_OVF_CLR = 1'b1; step();
        chk("ovfclr_a_ovf", a_ovf, 0);

        M_WR = 1'b1; M_DIN = 8'h66; S_RD = 1'b1; step();
        chk("pp66_a_cnt", a_cnt, 4);     chk("pp66_a_ovf", a_ovf, 0);
        chk("pp66_a_full", a_full, 1);   chk("pp66_a_sdout", a_sdout, 8'h22);
        chk("pp66_b_sdout", b_sdout, 8'h22); chk("pp66_c_sdout", c_sdout, 8'h66);
        chk("pp66_c_cnt", c_cnt, 1);

        for (int i = 0; i < 4; i++) begin
            S_RD = 1'b1; step();
            chk($sformatf("pop%0d_a_sdout", i), a_sdout, a_pop_exp[i]);
            chk($sformatf("pop%0d_a_cnt", i), a_cnt, 3 - i);
            chk($sformatf("pop%0d_b_sdout", i), b_sdout, b_pop_exp[i]);
            chk($sformatf("pop%0d_b_irq", i), b_irq, (i < 3) ? 1 : 0);
            chk($sformatf("pop%0d_c_cnt", i), c_cnt, 0);
        end
        chk("drain_a_empty", a_empty, 1); chk("drain_a_full", a_full, 0);
        chk("drain_c_sdout", c_sdout, 0); chk("drain_c_empty", c_empty, 1);

        S_RD = 1'b1; step();
        chk("popempty_a_cnt", a_cnt, 0); chk("popempty_a_sdout", a_sdout, 0);

        M_WR = 1'b1; M_DIN = 8'h99; S_RD = 1'b1; step();
        chk("pp_empty_a_cnt", a_cnt, 1); chk("pp_empty_a_sdout", a_sdout, 8'h99);
        chk("pp_empty_b_irq", b_irq, 1); chk("pp_empty_c_sdout", c_sdout, 8'h99);

        S_WR_REPLY = 1'b1; S_DIN = 8'hA5; step();
        chk("rep_a_mdout", a_mdout, 8'hA5); chk("rep_a_valid", a_valid, 1);
        chk("rep_c_mdout", c_mdout, 8'hA5);

        M_RD_REPLY = 1'b1; S_WR_REPLY = 1'b1; S_DIN = 8'h5A; step();
        chk("repboth_a_mdout", a_mdout, 8'h5A); chk("repboth_a_valid", a_valid, 1);

        M_RD_REPLY = 1'b1; step();
        chk("repread_a_valid", a_valid, 0); chk("repread_a_mdout", a_mdout, 8'h5A);

        M_WR = 1'b1; M_DIN = 8'h77; step();
        chk("p77_c_sdout", c_sdout, 8'h77);

        // asynchronous reset mid-cycle, observed before the next clock edge
        #2 nRESET = 1'b0;
        #1;
        chk("arst_c_sdout", c_sdout, 0); chk("arst_c_cnt", c_cnt, 0);
        chk("arst_c_empty", c_empty, 1); chk("arst_c_irq", c_irq, 0);
        chk("arst_c_mdout", c_mdout, 0); chk("arst_a_cnt", a_cnt, 0);
        chk("arst_a_sdout", a_sdout, 0); chk("arst_a_mdout", a_mdout, 0);
        chk("arst_b_irq", b_irq, 0);
        @(posedge CLK);
        #1;
        nRESET = 1'b1;

        M_WR = 1'b1; M_DIN = 8'h88; step();
        chk("post_c_sdout", c_sdout, 8'h88); chk("post_c_irq", c_irq, 1);
        chk("post_a_cnt", a_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
